ro_meas_ctrl: RTL

RO_MEAS_CTRL -- requirements
Module: ro_meas_ctrl

---
 rtl/ro_meas_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator frequency measurement sequencer: enables one RO, lets it settle,
// counts its synchronized rising edges over a programmable clk window and reports the result.
module ro_meas_ctrl #(
    parameter int unsigned NUM_RO     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [$clog2(NUM_RO)-1:0] sel,
    input  logic [15:0]               win_len,
    input  logic [NUM_RO-1:0]         ro_clk,
    output logic [NUM_RO-1:0]         ro_en,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count,
    output logic [$clog2(NUM_RO)-1:0] ro_id,
    output logic                      overflow
);

    localparam int unsigned SEL_W = $clog2(NUM_RO);
    localparam int unsigned WIN_W = 16;
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0] DRAIN_LAST  = WIN_W'(2);

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DRAIN, DONE} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   tmr;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_i;
    logic               sync1, sync2, sync3, ro_rise;
    logic [NUM_RO-1:0]  sel_mask_c;
    logic [NUM_RO-1:0]  lat_mask_c;

    assign sel_mask_c = NUM_RO'(1) << sel;
    assign lat_mask_c = NUM_RO'(1) << sel_q;

    // Selected RO into a 2-flop synchronizer, then a registered rising-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            ro_rise <= 1'b0;
        end else begin
            sync1   <= |(ro_clk & lat_mask_c);
            sync2   <= sync1;
            sync3   <= sync2;
            ro_rise <= sync2 & ~sync3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            win_q    <= '0;
            tmr      <= '0;
            cnt      <= '0;
            ovf_i    <= 1'b0;
            ro_en    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            ro_id    <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        sel_q <= sel;
                        win_q <= win_len;
                        tmr   <= '0;
                        cnt   <= '0;
                        ovf_i <= 1'b0;
                        ro_en <= sel_mask_c;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        ro_en <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= '0;
                        if (tmr == SETTLE_LAST) begin
                            tmr <= '0;
                            if (win_q == '0) begin
                                ro_en <= '0;
                                state <= DRAIN;
                            end else begin
                                state <= MEASURE;
                            end
                        end else begin
                            tmr <= tmr + WIN_W'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        ro_en <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Saturate instead of wrapping; a dropped edge marks overflow.
                        if (ro_rise) begin
                            if (cnt == {CNT_W{1'b1}}) begin
                                ovf_i <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        if (tmr == win_q - WIN_W'(1)) begin
                            tmr   <= '0;
                            ro_en <= '0;
                            state <= DRAIN;
                        end else begin
                            tmr <= tmr + WIN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tmr == DRAIN_LAST) begin
                        tmr   <= '0;
                        state <= DONE;
                    end else begin
                        tmr <= tmr + WIN_W'(1);
                    end
                end
                DONE: begin
                    count    <= cnt;
                    ro_id    <= sel_q;
                    overflow <= ovf_i;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    ro_en <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
